// File: rtl/inputc_vcn.sv
// Router input unit: NVC virtual-channel buffers with per-VC packet FSM and round-robin switch request.
// Latency: a flit is requested the cycle after it is written; output is registered one cycle after grant.
// Backpressure: ordy[v] deasserts when VC v is full; a write to a full VC is dropped unless that VC pops the same cycle.

// Generic show-ahead FIFO used for each VC buffer.
// Latency: a written entry is visible at rd_dat on the following cycle.
// Backpressure: a write while full is accepted only alongside a read; otherwise it is dropped and flagged on drop.
module inputc_vcn_fifo #(
    parameter int W     = 66,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_,
    input  logic         wr_vld,
    input  logic [W-1:0] wr_dat,
    input  logic         rd_en,
    output logic [W-1:0] rd_dat,
    output logic         full,
    output logic         empty,
    output logic         drop
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   cnt;
    logic          wr_ok;
    logic          rd_ok;

    assign full   = (cnt == FULL_CNT);
    assign empty  = (cnt == '0);
    assign rd_ok  = rd_en && !empty;
    // A pop frees the slot in the same cycle, so a write to a full FIFO is still taken.
    assign wr_ok  = wr_vld && (!full || rd_ok);
    assign drop   = wr_vld && full && !rd_ok;
    assign rd_dat = mem[rptr];

    // Storage array; contents need no reset since cnt gates every read.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wptr] <= wr_dat;
        end
    end

    // Pointers wrap naturally at power-of-two DEPTH; cnt tracks occupancy.
    always_ff @(posedge clk) begin
        if (rst_) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (wr_ok) wptr <= wptr + AW'(1);
            if (rd_ok) rptr <= rptr + AW'(1);
            case ({wr_ok, rd_ok})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

module inputc_vcn #(
    parameter int DATAW = 64,
    parameter int NVC   = 2,
    parameter int DEPTH = 4,
    parameter int NPORT = 5,
    parameter int PORTW = $clog2(NPORT),
    parameter int VCW   = $clog2(NVC)
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic [DATAW-1:0] idata,
    input  logic [1:0]       itype,
    input  logic             ivalid,
    input  logic [VCW-1:0]   ivch,
    output logic [NVC-1:0]   ordy,
    output logic             req,
    output logic [PORTW-1:0] port,
    input  logic             grt,
    output logic [DATAW-1:0] odata,
    output logic [1:0]       otype,
    output logic             ovalid,
    output logic [VCW-1:0]   ovch,
    output logic [NVC-1:0]   olck,
    output logic             err
);
    localparam logic [1:0] T_HEAD     = 2'd0;
    localparam logic [1:0] T_BODY     = 2'd1;
    localparam logic [1:0] T_TAIL     = 2'd2;
    localparam logic [1:0] T_HEADTAIL = 2'd3;

    typedef enum logic {IDLE, ACTIVE} vc_state_t;

    vc_state_t        state_q  [NVC];
    vc_state_t        state_d  [NVC];
    logic [PORTW-1:0] route_q  [NVC];
    logic [DATAW+1:0] front    [NVC];
    logic [NVC-1:0]   fifo_full;
    logic [NVC-1:0]   fifo_empty;
    logic [NVC-1:0]   fifo_drop;
    logic [NVC-1:0]   pop;
    logic [NVC-1:0]   elig;
    logic [NVC-1:0]   discard;
    logic [NVC-1:0]   bad_head;
    logic [VCW-1:0]   rr_q;
    logic [VCW-1:0]   sel;
    logic             grant;

    for (genvar v = 0; v < NVC; v++) begin : g_vc
        inputc_vcn_fifo #(.W(DATAW + 2), .DEPTH(DEPTH)) u_fifo (
            .clk    (clk),
            .rst_   (rst_),
            .wr_vld (ivalid && (ivch == VCW'(v))),
            .wr_dat ({itype, idata}),
            .rd_en  (pop[v]),
            .rd_dat (front[v]),
            .full   (fifo_full[v]),
            .empty  (fifo_empty[v]),
            .drop   (fifo_drop[v])
        );
    end

    assign ordy  = ~fifo_full;
    assign grant = req && grt;

    // Classify each VC's front flit: requestable, stray body/tail to discard, or misplaced head.
    always_comb begin
        elig     = '0;
        discard  = '0;
        bad_head = '0;
        olck     = '0;
        for (int v = 0; v < NVC; v++) begin
            logic is_head;
            is_head     = (front[v][DATAW+1:DATAW] == T_HEAD) ||
                          (front[v][DATAW+1:DATAW] == T_HEADTAIL);
            olck[v]     = (state_q[v] == ACTIVE);
            elig[v]     = !fifo_empty[v] && ((state_q[v] == ACTIVE) || is_head);
            discard[v]  = !fifo_empty[v] && (state_q[v] == IDLE) && !is_head;
            bad_head[v] = !fifo_empty[v] && (state_q[v] == ACTIVE) && is_head;
        end
    end

    // Round-robin pick: scan from rr_q upward, first eligible VC wins.
    always_comb begin
        sel = '0;
        req = 1'b0;
        for (int i = 0; i < NVC; i++) begin
            int idx;
            idx = (int'(rr_q) + i) % NVC;
            if (!req && elig[idx]) begin
                req = 1'b1;
                sel = VCW'(idx);
            end
        end
    end

    // Requested port: latched route while a packet is in flight, else the head flit's own field.
    always_comb begin
        port = '0;
        if (req) begin
            if (state_q[sel] == ACTIVE) port = route_q[sel];
            else                        port = front[sel][PORTW-1:0];
        end
    end

    // Per-VC FSM next state and pop strobes; discards pop without a grant.
    always_comb begin
        for (int v = 0; v < NVC; v++) begin
            state_d[v] = state_q[v];
            pop[v]     = discard[v];
            if (grant && (sel == VCW'(v))) begin
                pop[v] = 1'b1;
                if ((state_q[v] == IDLE) && (front[v][DATAW+1:DATAW] == T_HEAD)) begin
                    state_d[v] = ACTIVE;
                end else if ((state_q[v] == ACTIVE) && (front[v][DATAW+1:DATAW] == T_TAIL)) begin
                    state_d[v] = IDLE;
                end
            end
        end
    end

    // FSM state, route registers and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst_) begin
            for (int v = 0; v < NVC; v++) begin
                state_q[v] <= IDLE;
                route_q[v] <= '0;
            end
            rr_q <= '0;
        end else begin
            for (int v = 0; v < NVC; v++) begin
                state_q[v] <= state_d[v];
            end
            if (grant) begin
                if (state_q[sel] == IDLE) route_q[sel] <= front[sel][PORTW-1:0];
                if (int'(sel) == NVC - 1) rr_q <= '0;
                else                      rr_q <= sel + VCW'(1);
            end
        end
    end

    // Registered output stage; everything is zero on cycles without a forwarded flit.
    always_ff @(posedge clk) begin
        if (rst_ || !grant) begin
            odata  <= '0;
            otype  <= '0;
            ovalid <= 1'b0;
            ovch   <= '0;
        end else begin
            odata  <= front[sel][DATAW-1:0];
            otype  <= front[sel][DATAW+1:DATAW];
            ovalid <= 1'b1;
            ovch   <= sel;
        end
    end

    // Sticky error: overflow drop, stray body/tail while idle, or head while a packet is open.
    always_ff @(posedge clk) begin
        if (rst_) err <= 1'b0;
        else      err <= err | (|fifo_drop) | (|discard) | (|bad_head);
    end

    logic unused_type;
    assign unused_type = (T_BODY == 2'd1);
endmodule

// File: tb/tb_inputc_vcn.sv
// Directed bench for inputc_vcn with default parameters (DATAW 64, NVC 2, DEPTH 4, NPORT 5).
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
// Expected values are hand-computed constants per scenario.
module tb_inputc_vcn;
    logic        clk;
    logic        rst_;
    logic [63:0] idata;
    logic [1:0]  itype;
    logic        ivalid;
    logic [0:0]  ivch;
    logic [1:0]  ordy;
    logic        req;
    logic [2:0]  port;
    logic        grt;
    logic [63:0] odata;
    logic [1:0]  otype;
    logic        ovalid;
    logic [0:0]  ovch;
    logic [1:0]  olck;
    logic        err;

    int n_chk;
    int n_fail;

    inputc_vcn dut (
        .clk    (clk),
        .rst_   (rst_),
        .idata  (idata),
        .itype  (itype),
        .ivalid (ivalid),
        .ivch   (ivch),
        .ordy   (ordy),
        .req    (req),
        .port   (port),
        .grt    (grt),
        .odata  (odata),
        .otype  (otype),
        .ovalid (ovalid),
        .ovch   (ovch),
        .olck   (olck),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [0:0] vc, input logic [1:0] t, input logic [63:0] d);
        ivalid = v;
        ivch   = vc;
        itype  = t;
        idata  = d;
    endtask

    task automatic do_reset();
        rst_ = 1'b1;
        drive(1'b0, 1'b0, 2'd0, 64'h0);
        grt = 1'b0;
        tick();
        tick();
        rst_ = 1'b0;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_ordy"},   64'(ordy),   64'h3);
        check({pfx, "_req"},    64'(req),    64'h0);
        check({pfx, "_port"},   64'(port),   64'h0);
        check({pfx, "_odata"},  odata,       64'h0);
        check({pfx, "_otype"},  64'(otype),  64'h0);
        check({pfx, "_ovalid"}, 64'(ovalid), 64'h0);
        check({pfx, "_ovch"},   64'(ovch),   64'h0);
        check({pfx, "_olck"},   64'(olck),   64'h0);
        check({pfx, "_err"},    64'(err),    64'h0);
    endtask

    logic [63:0] exp_dat [4];
    logic [1:0]  exp_typ [4];
    logic [0:0]  exp_vc  [4];
    logic [2:0]  exp_prt [4];

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_   = 1'b1;
        grt    = 1'b0;
        drive(1'b0, 1'b0, 2'd0, 64'h0);

        // Reset state
        do_reset();
        check_reset_outputs("rst");

        // Single HEADTAIL on VC0, port 3, grant tied high
        grt = 1'b1;
        drive(1'b1, 1'b0, 2'd3, 64'hA0A0_0003);
        tick();
        drive(1'b0, 1'b0, 2'd0, 64'h0);
        check("ht_req",  64'(req),  64'h1);
        check("ht_port", 64'(port), 64'h3);
        check("ht_ov0",  64'(ovalid), 64'h0);
        tick();
        check("ht_ovalid", 64'(ovalid), 64'h1);
        check("ht_otype",  64'(otype),  64'h3);
        check("ht_ovch",   64'(ovch),   64'h0);
        check("ht_odata",  odata,       64'hA0A0_0003);
        check("ht_olck",   64'(olck),   64'h0);
        check("ht_req_after", 64'(req), 64'h0);
        tick();
        check("ht_ovalid_low", 64'(ovalid), 64'h0);
        check("ht_odata_low",  odata,       64'h0);

        // HEAD/BODY/TAIL on VC1, port 2; tail carries a bogus port field
        drive(1'b1, 1'b1, 2'd0, 64'h1111_0002);
        tick();
        check("p1_req",  64'(req),  64'h1);
        check("p1_port", 64'(port), 64'h2);
        check("p1_olck0", 64'(olck), 64'h0);
        drive(1'b1, 1'b1, 2'd1, 64'h2222_0000);
        tick();
        check("p1_h_ovalid", 64'(ovalid), 64'h1);
        check("p1_h_odata",  odata,       64'h1111_0002);
        check("p1_h_otype",  64'(otype),  64'h0);
        check("p1_h_ovch",   64'(ovch),   64'h1);
        check("p1_olck1",    64'(olck),   64'h2);
        drive(1'b1, 1'b1, 2'd2, 64'h3333_0005);
        tick();
        drive(1'b0, 1'b0, 2'd0, 64'h0);
        check("p1_b_odata", odata,      64'h2222_0000);
        check("p1_b_otype", 64'(otype), 64'h1);
        check("p1_olck2",   64'(olck),  64'h2);
        check("p1_tport",   64'(port),  64'h2);
        tick();
        check("p1_t_odata", odata,      64'h3333_0005);
        check("p1_t_otype", 64'(otype), 64'h2);
        check("p1_olck3",   64'(olck),  64'h0);
        check("p1_req_end", 64'(req),   64'h0);
        tick();
        check("p1_ovalid_end", 64'(ovalid), 64'h0);

        // Two packets loaded on VC0 and VC1, then drained with round-robin interleave
        grt = 1'b0;
        drive(1'b1, 1'b0, 2'd0, 64'h0A00_0001);
        tick();
        drive(1'b1, 1'b1, 2'd0, 64'h1B00_0004);
        tick();
        drive(1'b1, 1'b0, 2'd2, 64'h0C00_0000);
        tick();
        drive(1'b1, 1'b1, 2'd2, 64'h1D00_0000);
        tick();
        drive(1'b0, 1'b0, 2'd0, 64'h0);
        check("rr_ovalid_hold", 64'(ovalid), 64'h0);
        exp_dat[0] = 64'h0A00_0001; exp_typ[0] = 2'd0; exp_vc[0] = 1'b0; exp_prt[0] = 3'd1;
        exp_dat[1] = 64'h1B00_0004; exp_typ[1] = 2'd0; exp_vc[1] = 1'b1; exp_prt[1] = 3'd4;
        exp_dat[2] = 64'h0C00_0000; exp_typ[2] = 2'd2; exp_vc[2] = 1'b0; exp_prt[2] = 3'd1;
        exp_dat[3] = 64'h1D00_0000; exp_typ[3] = 2'd2; exp_vc[3] = 1'b1; exp_prt[3] = 3'd4;
        grt = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rr_port%0d", k), 64'(port), 64'(exp_prt[k]));
            tick();
            check($sformatf("rr_ovalid%0d", k), 64'(ovalid), 64'h1);
            check($sformatf("rr_ovch%0d", k),   64'(ovch),   64'(exp_vc[k]));
            check($sformatf("rr_otype%0d", k),  64'(otype),  64'(exp_typ[k]));
            check($sformatf("rr_odata%0d", k),  odata,       exp_dat[k]);
        end
        tick();
        check("rr_olck_end", 64'(olck), 64'h0);
        check("rr_err_clean", 64'(err), 64'h0);

        // Fill VC0, overflow, then write concurrent with a pop on the full FIFO
        grt = 1'b0;
        drive(1'b1, 1'b0, 2'd0, 64'h4000_0001);
        tick();
        drive(1'b1, 1'b0, 2'd1, 64'h4100_0000);
        tick();
        drive(1'b1, 1'b0, 2'd1, 64'h4200_0000);
        tick();
        check("full_ordy3", 64'(ordy), 64'h3);
        drive(1'b1, 1'b0, 2'd1, 64'h4300_0000);
        tick();
        check("full_ordy", 64'(ordy), 64'h2);
        check("full_err0", 64'(err),  64'h0);
        drive(1'b1, 1'b0, 2'd1, 64'h4400_0000);
        tick();
        check("ovf_err",  64'(err),  64'h1);
        check("ovf_ordy", 64'(ordy), 64'h2);
        grt = 1'b1;
        drive(1'b1, 1'b0, 2'd2, 64'h4500_0000);
        check("ovf_req",  64'(req),  64'h1);
        check("ovf_port", 64'(port), 64'h1);
        tick();
        drive(1'b0, 1'b0, 2'd0, 64'h0);
        check("popw_odata", odata,      64'h4000_0001);
        check("popw_ordy",  64'(ordy),  64'h2);
        check("popw_olck",  64'(olck),  64'h1);
        exp_dat[0] = 64'h4100_0000; exp_typ[0] = 2'd1;
        exp_dat[1] = 64'h4200_0000; exp_typ[1] = 2'd1;
        exp_dat[2] = 64'h4300_0000; exp_typ[2] = 2'd1;
        exp_dat[3] = 64'h4500_0000; exp_typ[3] = 2'd2;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("drain_odata%0d", k), odata,      exp_dat[k]);
            check($sformatf("drain_otype%0d", k), 64'(otype), 64'(exp_typ[k]));
        end
        check("drain_olck", 64'(olck), 64'h0);
        check("drain_ordy", 64'(ordy), 64'h3);
        check("drain_req",  64'(req),  64'h0);

        // Stray BODY to an idle VC is discarded with an error
        do_reset();
        check("r2_err", 64'(err), 64'h0);
        grt = 1'b1;
        drive(1'b1, 1'b1, 2'd1, 64'h0000_0005);
        tick();
        drive(1'b0, 1'b0, 2'd0, 64'h0);
        check("stray_req", 64'(req), 64'h0);
        tick();
        check("stray_err",    64'(err),    64'h1);
        check("stray_req2",   64'(req),    64'h0);
        check("stray_ovalid", 64'(ovalid), 64'h0);
        check("stray_ordy",   64'(ordy),   64'h3);
        tick();
        check("stray_ovalid2", 64'(ovalid), 64'h0);

        // Reset in the middle of a packet, then a clean HEADTAIL
        do_reset();
        grt = 1'b1;
        drive(1'b1, 1'b0, 2'd0, 64'h6000_0002);
        tick();
        drive(1'b1, 1'b0, 2'd1, 64'h6100_0000);
        tick();
        check("mid_olck", 64'(olck), 64'h1);
        check("mid_ovalid", 64'(ovalid), 64'h1);
        grt = 1'b0;
        drive(1'b1, 1'b0, 2'd1, 64'h6200_0000);
        tick();
        drive(1'b0, 1'b0, 2'd0, 64'h0);
        rst_ = 1'b1;
        tick();
        rst_ = 1'b0;
        check_reset_outputs("mid");
        grt = 1'b1;
        tick();
        check("post_req",    64'(req),    64'h0);
        check("post_ovalid", 64'(ovalid), 64'h0);
        drive(1'b1, 1'b1, 2'd3, 64'h7000_0004);
        tick();
        drive(1'b0, 1'b0, 2'd0, 64'h0);
        check("post_req2", 64'(req),  64'h1);
        check("post_port", 64'(port), 64'h4);
        tick();
        check("post_ovalid2", 64'(ovalid), 64'h1);
        check("post_ovch",    64'(ovch),   64'h1);
        check("post_otype",   64'(otype),  64'h3);
        check("post_odata",   odata,       64'h7000_0004);
        check("post_olck",    64'(olck),   64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/inputc_vcn.md
INPUTC_VCN -- requirements
Module: inputc_vcn

Interface
REQ-001 Parameter DATAW, default 64, flit payload width in bits.
REQ-002 Parameter NVC, default 2, number of input virtual channels (VCs), range 2..8.
REQ-003 Parameter DEPTH, default 4, flits per VC buffer, power of two, minimum 2.
REQ-004 Parameter NPORT, default 5, number of router output ports; PORTW = clog2(NPORT), VCW = clog2(NVC).
REQ-005 The block SHALL use one clock; reset is synchronous and active-high.
REQ-006 clk  in  1  sole clock, rising edge.
REQ-007 rst_  in  1  synchronous, active-high reset.
REQ-008 idata  in  DATAW  incoming flit payload; on a head flit, bits [PORTW-1:0] carry the destination output port.
REQ-009 itype  in  2  flit type: 0 HEAD, 1 BODY, 2 TAIL, 3 HEADTAIL.
REQ-010 ivalid  in  1  idata, itype and ivch are valid this cycle.
REQ-011 ivch  in  VCW  target input VC of the incoming flit.
REQ-012 ordy  out  NVC  per-VC buffer-not-full indication to the upstream router.
REQ-013 req  out  1  switch request for the currently selected VC.
REQ-014 port  out  PORTW  output port requested by the selected VC.
REQ-015 grt  in  1  switch grant for this input, valid in the same cycle as req.
REQ-016 odata  out  DATAW  forwarded flit, registered.
REQ-017 otype  out  2  type of the forwarded flit, registered.
REQ-018 ovalid  out  1  odata, otype and ovch are valid.
REQ-019 ovch  out  VCW  input VC that sourced odata.
REQ-020 olck  out  NVC  per-VC flag: VC holds an allocated output port (packet in flight).
REQ-021 err  out  1  sticky protocol-error flag.

Function
REQ-022 Each VC SHALL own a DEPTH-entry FIFO storing {itype, idata}; the FIFO accepts a write when ivalid=1 and ivch selects it.
REQ-023 ordy[v] SHALL equal 1 when FIFO v holds fewer than DEPTH entries.
REQ-024 A write to a full FIFO SHALL be dropped and SHALL set err, except when the same VC is popped in that cycle; that write SHALL be accepted.
REQ-025 Read and write pointers SHALL wrap modulo DEPTH; occupancy SHALL be tracked with a (clog2(DEPTH)+1)-bit counter.
REQ-026 Each VC SHALL have an FSM with states IDLE and ACTIVE.
REQ-027 In IDLE, a FIFO front of type HEAD or HEADTAIL SHALL make the VC eligible and latch port = data[PORTW-1:0] into the VC route register when first granted.
REQ-028 In IDLE, a FIFO front of type BODY or TAIL SHALL be popped and discarded without request, and SHALL set err.
REQ-029 A granted HEAD SHALL move the VC IDLE->ACTIVE; a granted TAIL SHALL move it ACTIVE->IDLE; a granted HEADTAIL SHALL leave it in IDLE.
REQ-030 In ACTIVE, a VC SHALL be eligible whenever its FIFO is non-empty and SHALL request its latched port.
REQ-031 A HEAD or HEADTAIL at the FIFO front while ACTIVE SHALL be treated as a body flit and SHALL set err.
REQ-032 olck[v] SHALL be 1 exactly while VC v is ACTIVE.
REQ-033 A round-robin selector SHALL pick one eligible VC per cycle, starting from the VC after the last granted one; req=1 iff an eligible VC exists.
REQ-034 port SHALL be combinational: the route register of the selected VC when ACTIVE, otherwise the head flit's port field.
REQ-035 When req=1 and grt=1, the selected VC SHALL be popped in that cycle, the round-robin pointer SHALL advance past it, and {odata, otype, ovch} SHALL be registered with ovalid=1 on the next cycle.
REQ-036 When grt=0 or req=0, ovalid SHALL be 0 on the next cycle; odata and otype SHALL be zero when ovalid=0.
REQ-037 grt while req=0 SHALL be ignored.
REQ-038 Flits of different VCs MAY interleave at the output; flits within a VC SHALL stay in order.
REQ-039 Throughput SHALL be one flit per cycle, with 1-cycle FIFO-to-output latency after grant.

Reset
REQ-040 When rst_=1 at a clock edge: all FIFOs empty, pointers 0, FSMs IDLE, round-robin pointer 0, route registers 0.
REQ-041 Outputs after reset: ordy all 1, req 0, port 0, odata 0, otype 0, ovalid 0, ovch 0, olck 0, err 0.
REQ-042 Reset mid-packet SHALL discard all buffered flits with no output.

Verification
REQ-043 HEADTAIL to VC0 with port 3, grt tied 1 -> req=1 and port=3 the cycle after the write; ovalid=1, otype=3, ovch=0 one cycle later; olck[0] stays 0.
REQ-044 HEAD/BODY/TAIL to VC1 with port 2 -> olck[1]=1 from the cycle after the head grant until the cycle after the tail grant; three outputs in order.
REQ-045 Packets on VC0 and VC1 simultaneously, grt=1 -> outputs alternate VC0, VC1, VC0, ...
REQ-046 DEPTH writes to VC0 with grt=0 -> ordy[0]=0; a 5th write sets err and is dropped; a write concurrent with a pop on a full FIFO is accepted.
REQ-047 BODY to an IDLE VC -> no req, err=1, FIFO empty next cycle.
REQ-048 rst_ asserted with a half-sent packet -> all outputs at reset values next cycle; a subsequent HEADTAIL is forwarded normally.
